// File: rtl/usb_pd_tx_sched.sv
// USB-PD transmit scheduler: arbitrates Hard Reset / GoodCRC / message, drives the PHY writer
// handshake, owns MessageID and waits for GoodCRC. Define USB_PD_TX_RETRY_EN to build retries.
module usb_pd_tx_sched #(
  parameter int unsigned system_khz     = 200000,
  parameter int unsigned CRC_TIMEOUT_US = 1000,
  parameter int unsigned RETRY_MAX      = 2
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        hrst_req,
  output logic        hrst_done,
  input  logic        gcrc_req,
  input  logic [2:0]  gcrc_id,
  output logic        gcrc_ack,
  input  logic        msg_req,
  input  logic [2:0]  msg_num,
  input  logic [3:0]  msg_type,
  input  logic [31:0] msg_word0,
  input  logic [31:0] msg_word1,
  input  logic [31:0] msg_word2,
  input  logic [31:0] msg_word3,
  input  logic [31:0] msg_word4,
  input  logic [31:0] msg_word5,
  input  logic [31:0] msg_word6,
  output logic        msg_done,
  output logic        msg_fail,
  input  logic        rx_gcrc_valid,
  input  logic [2:0]  rx_gcrc_id,
  output logic [2:0]  msg_id,
  output logic        phy_start,
  input  logic        phy_busy,
  output logic        phy_hrst,
  output logic [2:0]  phy_id,
  output logic [2:0]  phy_num,
  output logic [3:0]  phy_type,
  output logic [31:0] phy_word0,
  output logic [31:0] phy_word1,
  output logic [31:0] phy_word2,
  output logic [31:0] phy_word3,
  output logic [31:0] phy_word4,
  output logic [31:0] phy_word5,
  output logic [31:0] phy_word6
);

  localparam int unsigned Ticks    = system_khz * CRC_TIMEOUT_US / 1000;
  localparam logic [31:0] TickLast = 32'(Ticks - 1);

  if (Ticks < 1 || RETRY_MAX > 255) begin : gen_cfg_check
    $error("usb_pd_tx_sched: GoodCRC window must be >= 1 tick and RETRY_MAX <= 255");
  end

  typedef enum logic [2:0] {
    StIdle, StLaunch, StWaitBusy, StWaitDone, StWaitGcrc, StReport
  } state_e;

  typedef enum logic [1:0] {KindHrst, KindGcrc, KindMsg} kind_e;

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [31:0] timer_q, timer_d;
  logic [2:0]  msg_id_q, msg_id_d;
  logic        phy_hrst_q, phy_hrst_d;
  logic [2:0]  phy_id_q, phy_id_d;
  logic [2:0]  phy_num_q, phy_num_d;
  logic [3:0]  phy_type_q, phy_type_d;
  logic        phy_start_q, phy_start_d;
  logic        hrst_done_q, hrst_done_d;
  logic        gcrc_ack_q, gcrc_ack_d;
  logic        msg_done_q, msg_done_d;
  logic        msg_fail_q, msg_fail_d;
  logic        retry_inc, retry_clr, retry_ok;

`ifdef USB_PD_TX_RETRY_EN
  localparam int unsigned RetryW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  logic [RetryW-1:0] retry_cnt_q, retry_cnt_d;

  assign retry_ok = retry_cnt_q < RetryW'(RETRY_MAX);

  always_comb begin
    retry_cnt_d = retry_cnt_q;
    if (retry_clr) begin
      retry_cnt_d = '0;
    end else if (retry_inc) begin
      retry_cnt_d = retry_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      retry_cnt_q <= '0;
    end else begin
      retry_cnt_q <= retry_cnt_d;
    end
  end
`else
  logic unused_retry;
  assign retry_ok     = 1'b0;
  assign unused_retry = retry_inc ^ retry_clr;
`endif

  always_comb begin
    state_d     = state_q;
    kind_d      = kind_q;
    timer_d     = timer_q;
    msg_id_d    = msg_id_q;
    phy_hrst_d  = phy_hrst_q;
    phy_id_d    = phy_id_q;
    phy_num_d   = phy_num_q;
    phy_type_d  = phy_type_q;
    hrst_done_d = 1'b0;
    gcrc_ack_d  = 1'b0;
    msg_done_d  = 1'b0;
    msg_fail_d  = 1'b0;
    retry_inc   = 1'b0;
    retry_clr   = 1'b0;

    case (state_q)
      StIdle: begin
        if (hrst_req) begin
          kind_d     = KindHrst;
          phy_hrst_d = 1'b1;
          phy_id_d   = 3'd0;
          phy_num_d  = 3'd0;
          phy_type_d = 4'h0;
          state_d    = StLaunch;
        end else if (gcrc_req) begin
          kind_d     = KindGcrc;
          phy_hrst_d = 1'b0;
          phy_id_d   = gcrc_id;
          phy_num_d  = 3'd0;
          phy_type_d = 4'h1;
          state_d    = StLaunch;
        end else if (msg_req) begin
          kind_d     = KindMsg;
          phy_hrst_d = 1'b0;
          phy_id_d   = msg_id_q;
          phy_num_d  = msg_num;
          phy_type_d = msg_type;
          state_d    = StLaunch;
        end
      end
      StLaunch: state_d = StWaitBusy;
      StWaitBusy: begin
        if (phy_busy) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        // Frame in flight always completes; the PHY writer cannot be aborted.
        if (!phy_busy) begin
          case (kind_q)
            KindHrst: begin
              hrst_done_d = 1'b1;
              msg_id_d    = 3'd0;
              state_d     = StReport;
            end
            KindGcrc: begin
              gcrc_ack_d = 1'b1;
              state_d    = StReport;
            end
            default: begin
              timer_d = 32'd0;
              state_d = StWaitGcrc;
            end
          endcase
        end
      end
      StWaitGcrc: begin
        timer_d = timer_q + 32'd1;
        // A match on the last window cycle still counts as success.
        if (rx_gcrc_valid && (rx_gcrc_id == msg_id_q)) begin
          msg_done_d = 1'b1;
          msg_id_d   = msg_id_q + 3'd1;
          state_d    = StReport;
        end else if (hrst_req) begin
          msg_fail_d = 1'b1;
          retry_clr  = 1'b1;
          state_d    = StIdle;
        end else if (timer_q == TickLast) begin
          if (retry_ok) begin
            retry_inc = 1'b1;
            state_d   = StLaunch;
          end else begin
            msg_fail_d = 1'b1;
            state_d    = StReport;
          end
        end
      end
      StReport: begin
        retry_clr = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    phy_start_d = (state_d == StLaunch);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      kind_q      <= KindHrst;
      timer_q     <= 32'd0;
      msg_id_q    <= 3'd0;
      phy_hrst_q  <= 1'b0;
      phy_id_q    <= 3'd0;
      phy_num_q   <= 3'd0;
      phy_type_q  <= 4'h0;
      phy_start_q <= 1'b0;
      hrst_done_q <= 1'b0;
      gcrc_ack_q  <= 1'b0;
      msg_done_q  <= 1'b0;
      msg_fail_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      kind_q      <= kind_d;
      timer_q     <= timer_d;
      msg_id_q    <= msg_id_d;
      phy_hrst_q  <= phy_hrst_d;
      phy_id_q    <= phy_id_d;
      phy_num_q   <= phy_num_d;
      phy_type_q  <= phy_type_d;
      phy_start_q <= phy_start_d;
      hrst_done_q <= hrst_done_d;
      gcrc_ack_q  <= gcrc_ack_d;
      msg_done_q  <= msg_done_d;
      msg_fail_q  <= msg_fail_d;
    end
  end

  assign msg_id    = msg_id_q;
  assign phy_start = phy_start_q;
  assign phy_hrst  = phy_hrst_q;
  assign phy_id    = phy_id_q;
  assign phy_num   = phy_num_q;
  assign phy_type  = phy_type_q;
  assign hrst_done = hrst_done_q;
  assign gcrc_ack  = gcrc_ack_q;
  assign msg_done  = msg_done_q;
  assign msg_fail  = msg_fail_q;

  assign phy_word0 = msg_word0;
  assign phy_word1 = msg_word1;
  assign phy_word2 = msg_word2;
  assign phy_word3 = msg_word3;
  assign phy_word4 = msg_word4;
  assign phy_word5 = msg_word5;
  assign phy_word6 = msg_word6;

endmodule

// File: tb/tb_usb_pd_tx_sched.sv
// Scoreboard bench for usb_pd_tx_sched; expected PHY frames and completion pulses are queued
// at stimulus time and compared against captured DUT activity. Honours USB_PD_TX_RETRY_EN.
module tb_usb_pd_tx_sched;

  localparam int T    = 300;  // 300 kHz * 1000 us / 1000
  localparam int BUSY = 50;
`ifdef USB_PD_TX_RETRY_EN
  localparam int ATTEMPTS = 3;
`else
  localparam int ATTEMPTS = 1;
`endif

  typedef struct packed {
    logic       v;
    logic       hrst;
    logic [2:0] id;
    logic [2:0] num;
    logic [3:0] typ;
  } frame_t;

  typedef struct packed {
    logic       v;
    logic [3:0] p;   // {hrst_done, gcrc_ack, msg_done, msg_fail}
    logic [2:0] id;  // msg_id in the pulse cycle
  } evt_t;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        hrst_req = 1'b0, gcrc_req = 1'b0, msg_req = 1'b0;
  logic [2:0]  gcrc_id = '0, msg_num = '0, rx_gcrc_id = '0;
  logic [3:0]  msg_type = '0;
  logic [31:0] msg_word0 = '0, msg_word1 = '0, msg_word2 = '0, msg_word3 = '0;
  logic [31:0] msg_word4 = '0, msg_word5 = '0, msg_word6 = '0;
  logic        rx_gcrc_valid = 1'b0, phy_busy = 1'b0;
  logic        hrst_done, gcrc_ack, msg_done, msg_fail, phy_start, phy_hrst;
  logic [2:0]  msg_id, phy_id, phy_num;
  logic [3:0]  phy_type;
  logic [31:0] phy_word0, phy_word1, phy_word2, phy_word3, phy_word4, phy_word5, phy_word6;

  int errors = 0;
  int checks = 0;
  int cyc_n = 0;
  int phy_cnt = 0;
  int busy_len = BUSY;
  logic [2:0] exp_id = 3'd0;

  frame_t obs_f[$], exp_f[$];
  int     obs_f_cyc[$];
  evt_t   obs_e[$], exp_e[$];
  int     obs_e_cyc[$];

  usb_pd_tx_sched #(
    .system_khz    (300),
    .CRC_TIMEOUT_US(1000),
    .RETRY_MAX     (2)
  ) dut (
    .clock        (clock),
    .rst          (rst),
    .hrst_req     (hrst_req),
    .hrst_done    (hrst_done),
    .gcrc_req     (gcrc_req),
    .gcrc_id      (gcrc_id),
    .gcrc_ack     (gcrc_ack),
    .msg_req      (msg_req),
    .msg_num      (msg_num),
    .msg_type     (msg_type),
    .msg_word0    (msg_word0),
    .msg_word1    (msg_word1),
    .msg_word2    (msg_word2),
    .msg_word3    (msg_word3),
    .msg_word4    (msg_word4),
    .msg_word5    (msg_word5),
    .msg_word6    (msg_word6),
    .msg_done     (msg_done),
    .msg_fail     (msg_fail),
    .rx_gcrc_valid(rx_gcrc_valid),
    .rx_gcrc_id   (rx_gcrc_id),
    .msg_id       (msg_id),
    .phy_start    (phy_start),
    .phy_busy     (phy_busy),
    .phy_hrst     (phy_hrst),
    .phy_id       (phy_id),
    .phy_num      (phy_num),
    .phy_type     (phy_type),
    .phy_word0    (phy_word0),
    .phy_word1    (phy_word1),
    .phy_word2    (phy_word2),
    .phy_word3    (phy_word3),
    .phy_word4    (phy_word4),
    .phy_word5    (phy_word5),
    .phy_word6    (phy_word6)
  );

  always #5 clock = ~clock;

  // One clock; models the PHY writer and captures frames/pulses (no checking here).
  task automatic cyc();
    frame_t fr;
    evt_t   ev;
    @(posedge clock);
    #1;
    cyc_n++;
    if (phy_cnt > 0) begin
      phy_cnt--;
      if (phy_cnt == 0) phy_busy = 1'b0;
    end
    if (phy_start) begin
      phy_busy = 1'b1;
      phy_cnt  = busy_len;
      // Header fields are don't-care for a Hard Reset ordered set.
      fr = {1'b1, phy_hrst, phy_hrst ? 3'd0 : phy_id, phy_hrst ? 3'd0 : phy_num,
            phy_hrst ? 4'd0 : phy_type};
      obs_f.push_back(fr);
      obs_f_cyc.push_back(cyc_n);
    end
    if (hrst_done | gcrc_ack | msg_done | msg_fail) begin
      ev = {1'b1, hrst_done, gcrc_ack, msg_done, msg_fail, msg_id};
      obs_e.push_back(ev);
      obs_e_cyc.push_back(cyc_n);
    end
  endtask

  task automatic wait_frame(input int limit);
    for (int i = 0; i < limit && obs_f.size() == 0; i++) cyc();
  endtask

  task automatic wait_evt(input int limit);
    for (int i = 0; i < limit && obs_e.size() == 0; i++) cyc();
  endtask

  task automatic wait_phy(input int limit);
    for (int i = 0; i < limit && phy_busy; i++) cyc();
  endtask

  task automatic pulse_rx(input logic [2:0] id);
    rx_gcrc_valid = 1'b1;
    rx_gcrc_id    = id;
    cyc();
    rx_gcrc_valid = 1'b0;
  endtask

  task automatic take_frame(output frame_t got, output frame_t want, output int c);
    got  = '0;
    want = '0;
    c    = -1;
    if (obs_f.size() > 0) begin
      got = obs_f.pop_front();
      c   = obs_f_cyc.pop_front();
    end
    if (exp_f.size() > 0) want = exp_f.pop_front();
  endtask

  task automatic take_evt(output evt_t got, output evt_t want, output int c);
    got  = '0;
    want = '0;
    c    = -1;
    if (obs_e.size() > 0) begin
      got = obs_e.pop_front();
      c   = obs_e_cyc.pop_front();
    end
    if (exp_e.size() > 0) want = exp_e.pop_front();
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    msg_word0 = 32'hA5A5_0000; msg_word1 = 32'h1111_1111; msg_word2 = 32'h2222_2222;
    msg_word3 = 32'h3333_3333; msg_word4 = 32'h4444_4444; msg_word5 = 32'h5555_5555;
    msg_word6 = 32'hDEAD_BEEF;
    repeat (3) cyc();
    checks++;
    if ({phy_start, phy_hrst, phy_id, phy_num, phy_type, hrst_done, gcrc_ack, msg_done,
         msg_fail, msg_id} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs: got start=%b hrst=%b id=%0d num=%0d type=%h pulses=%b%b%b%b msg_id=%0d required all 0",
               phy_start, phy_hrst, phy_id, phy_num, phy_type, hrst_done, gcrc_ack, msg_done,
               msg_fail, msg_id);
    end
    checks++;
    if ({phy_word0, phy_word1, phy_word2, phy_word3, phy_word4, phy_word5, phy_word6} !==
        {msg_word0, msg_word1, msg_word2, msg_word3, msg_word4, msg_word5, msg_word6}) begin
      errors++;
      $display("FAIL word_passthrough: got w0=%h w6=%h required w0=%h w6=%h",
               phy_word0, phy_word6, msg_word0, msg_word6);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_single_msg();
    frame_t gf, ef;
    evt_t   ge, ee;
    int     c, req_c, rx_c;
    msg_num  = 3'd2;
    msg_type = 4'h2;
    busy_len = BUSY;
    exp_f.push_back({1'b1, 1'b0, exp_id, 3'd2, 4'h2});
    exp_e.push_back({1'b1, 4'b0010, exp_id + 3'd1});
    req_c   = cyc_n;
    msg_req = 1'b1;
    wait_frame(20);
    take_frame(gf, ef, c);
    checks++;
    if (gf !== ef) begin
      errors++;
      $display("FAIL single_frame: got %h required %h", gf, ef);
    end
    checks++;
    if (c !== req_c + 1) begin
      errors++;
      $display("FAIL start_latency: got cycle %0d required %0d", c, req_c + 1);
    end
    cyc();
    pulse_rx(exp_id);  // during WAIT_DONE, must be ignored
    wait_phy(BUSY + 10);
    repeat (100) cyc();
    rx_c = cyc_n + 1;
    pulse_rx(exp_id);
    wait_evt(10);
    take_evt(ge, ee, c);
    checks++;
    if (ge !== ee) begin
      errors++;
      $display("FAIL single_done: got %h required %h", ge, ee);
    end
    checks++;
    if (c !== rx_c) begin
      errors++;
      $display("FAIL single_done_cycle: got %0d required %0d", c, rx_c);
    end
    msg_req = 1'b0;
    exp_id  = exp_id + 3'd1;
    repeat (3) cyc();
    checks++;
    if (obs_f.size() !== 0) begin
      errors++;
      $display("FAIL single_start_count: got %0d extra starts required 0", obs_f.size());
    end
  endtask

  task automatic test_retry_timeout();
    frame_t gf, ef;
    evt_t   ge, ee;
    int     c, prev;
    msg_num  = 3'd1;
    msg_type = 4'h6;
    for (int a = 0; a < ATTEMPTS; a++) exp_f.push_back({1'b1, 1'b0, exp_id, 3'd1, 4'h6});
    exp_e.push_back({1'b1, 4'b0001, exp_id});
    msg_req = 1'b1;
    prev    = -1;
    for (int a = 0; a < ATTEMPTS; a++) begin
      wait_frame(T + BUSY + 20);
      take_frame(gf, ef, c);
      checks++;
      if (gf !== ef) begin
        errors++;
        $display("FAIL retry_frame%0d: got %h required %h", a, gf, ef);
      end
      if (a > 0) begin
        checks++;
        if (c - prev !== T + BUSY + 1) begin
          errors++;
          $display("FAIL retry_spacing%0d: got %0d cycles required %0d", a, c - prev, T + BUSY + 1);
        end
      end
      prev = c;
    end
    wait_evt(T + BUSY + 20);
    take_evt(ge, ee, c);
    checks++;
    if (ge !== ee) begin
      errors++;
      $display("FAIL retry_fail: got %h required %h", ge, ee);
    end
    checks++;
    if (c !== prev + T + BUSY + 1) begin
      errors++;
      $display("FAIL retry_fail_cycle: got %0d required %0d", c, prev + T + BUSY + 1);
    end
    msg_req = 1'b0;
    repeat (3) cyc();
  endtask

  task automatic test_priority();
    frame_t gf, ef;
    evt_t   ge, ee;
    int     c;
    msg_num  = 3'd1;
    msg_type = 4'h3;
    gcrc_id  = 3'd5;
    exp_f.push_back({1'b1, 1'b1, 3'd0, 3'd0, 4'h0});
    exp_f.push_back({1'b1, 1'b0, 3'd5, 3'd0, 4'h1});
    exp_f.push_back({1'b1, 1'b0, 3'd0, 3'd1, 4'h3});
    exp_e.push_back({1'b1, 4'b1000, 3'd0});
    exp_e.push_back({1'b1, 4'b0100, 3'd0});
    exp_e.push_back({1'b1, 4'b0010, 3'd1});
    hrst_req = 1'b1;
    gcrc_req = 1'b1;
    msg_req  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_frame(20);
      take_frame(gf, ef, c);
      checks++;
      if (gf !== ef) begin
        errors++;
        $display("FAIL prio_frame%0d: got %h required %h", k, gf, ef);
      end
      wait_phy(BUSY + 10);
      if (k == 2) begin
        repeat (10) cyc();
        pulse_rx(3'd0);
      end
      wait_evt(20);
      take_evt(ge, ee, c);
      checks++;
      if (ge !== ee) begin
        errors++;
        $display("FAIL prio_evt%0d: got %h required %h", k, ge, ee);
      end
      if (k == 0) hrst_req = 1'b0;
      if (k == 1) gcrc_req = 1'b0;
      if (k == 2) msg_req = 1'b0;
    end
    exp_id = 3'd1;
    repeat (3) cyc();
  endtask

  task automatic test_nonmatch();
    frame_t gf, ef;
    evt_t   ge, ee;
    int     c, c0, rx_c;
    msg_num  = 3'd3;
    msg_type = 4'h4;
    exp_f.push_back({1'b1, 1'b0, exp_id, 3'd3, 4'h4});
    exp_f.push_back({1'b1, 1'b0, exp_id, 3'd3, 4'h4});
`ifndef USB_PD_TX_RETRY_EN
    exp_e.push_back({1'b1, 4'b0001, exp_id});
`endif
    exp_e.push_back({1'b1, 4'b0010, exp_id + 3'd1});
    msg_req = 1'b1;
    wait_frame(20);
    take_frame(gf, ef, c0);
    checks++;
    if (gf !== ef) begin
      errors++;
      $display("FAIL nonmatch_frame: got %h required %h", gf, ef);
    end
    wait_phy(BUSY + 10);
    repeat (50) cyc();
    pulse_rx(exp_id + 3'd1);
`ifdef USB_PD_TX_RETRY_EN
    wait_frame(T + BUSY + 20);
    take_frame(gf, ef, c);
    checks++;
    if (gf !== ef) begin
      errors++;
      $display("FAIL nonmatch_retry_frame: got %h required %h", gf, ef);
    end
    checks++;
    if (c - c0 !== T + BUSY + 1) begin
      errors++;
      $display("FAIL nonmatch_spacing: got %0d required %0d", c - c0, T + BUSY + 1);
    end
`else
    wait_evt(T + 20);
    take_evt(ge, ee, c);
    checks++;
    if (ge !== ee) begin
      errors++;
      $display("FAIL nonmatch_fail: got %h required %h", ge, ee);
    end
    msg_req = 1'b0;
    cyc();
    msg_req = 1'b1;
    wait_frame(20);
    take_frame(gf, ef, c);
    checks++;
    if (gf !== ef) begin
      errors++;
      $display("FAIL nonmatch_resend_frame: got %h required %h", gf, ef);
    end
`endif
    // Match on the very last cycle of the window must beat the timeout.
    wait_phy(BUSY + 10);
    repeat (T) cyc();
    rx_c = cyc_n + 1;
    pulse_rx(exp_id);
    wait_evt(10);
    take_evt(ge, ee, c);
    checks++;
    if (ge !== ee) begin
      errors++;
      $display("FAIL edge_match: got %h required %h", ge, ee);
    end
    checks++;
    if (c !== rx_c) begin
      errors++;
      $display("FAIL edge_match_cycle: got %0d required %0d", c, rx_c);
    end
    msg_req = 1'b0;
    exp_id  = exp_id + 3'd1;
    repeat (3) cyc();
    checks++;
    if (obs_f.size() !== 0) begin
      errors++;
      $display("FAIL edge_no_retry: got %0d extra starts required 0", obs_f.size());
    end
  endtask

  task automatic test_rst_mid();
    frame_t gf, ef;
    int     c;
    msg_num  = 3'd4;
    msg_type = 4'h5;
    exp_f.push_back({1'b1, 1'b0, exp_id, 3'd4, 4'h5});
    msg_req = 1'b1;
    wait_frame(20);
    take_frame(gf, ef, c);
    checks++;
    if (gf !== ef) begin
      errors++;
      $display("FAIL rst_frame: got %h required %h", gf, ef);
    end
    repeat (10) cyc();
    checks++;
    if (msg_id !== exp_id) begin
      errors++;
      $display("FAIL pre_rst_msg_id: got %0d required %0d", msg_id, exp_id);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({phy_start, phy_hrst, phy_id, phy_num, phy_type, hrst_done, gcrc_ack, msg_done,
         msg_fail, msg_id} !== 19'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got id=%0d num=%0d type=%h msg_id=%0d required all 0",
               phy_id, phy_num, phy_type, msg_id);
    end
    msg_req  = 1'b0;
    phy_busy = 1'b0;
    phy_cnt  = 0;
    repeat (2) cyc();
    rst = 1'b0;
    repeat (2) cyc();
    exp_id = 3'd0;
  endtask

  task automatic test_hrst_abort();
    frame_t gf, ef;
    evt_t   ge, ee;
    int     c, hc;
    msg_num  = 3'd1;
    msg_type = 4'h7;
    exp_f.push_back({1'b1, 1'b0, exp_id, 3'd1, 4'h7});
    exp_f.push_back({1'b1, 1'b1, 3'd0, 3'd0, 4'h0});
    exp_e.push_back({1'b1, 4'b0001, exp_id});
    exp_e.push_back({1'b1, 4'b1000, 3'd0});
    msg_req = 1'b1;
    wait_frame(20);
    take_frame(gf, ef, c);
    checks++;
    if (gf !== ef) begin
      errors++;
      $display("FAIL abort_frame: got %h required %h", gf, ef);
    end
    wait_phy(BUSY + 10);
    repeat (20) cyc();
    hrst_req = 1'b1;
    hc       = cyc_n;
    cyc();
    take_evt(ge, ee, c);
    checks++;
    if (ge !== ee || c !== hc + 1) begin
      errors++;
      $display("FAIL abort_fail: got %h at %0d required %h at %0d", ge, c, ee, hc + 1);
    end
    msg_req = 1'b0;
    wait_frame(10);
    take_frame(gf, ef, c);
    checks++;
    if (gf !== ef || c !== hc + 2) begin
      errors++;
      $display("FAIL abort_hrst_frame: got %h at %0d required %h at %0d", gf, c, ef, hc + 2);
    end
    wait_phy(BUSY + 10);
    wait_evt(10);
    take_evt(ge, ee, c);
    checks++;
    if (ge !== ee) begin
      errors++;
      $display("FAIL abort_hrst_done: got %h required %h", ge, ee);
    end
    hrst_req = 1'b0;
    exp_id   = 3'd0;
    repeat (3) cyc();
  endtask

  task automatic test_back_to_back_wrap();
    frame_t gf, ef;
    evt_t   ge, ee;
    int     c;
    busy_len = 4;
    for (int i = 0; i < 8; i++) begin
      msg_num  = i[2:0];
      msg_type = 4'h8 + i[3:0];
      exp_f.push_back({1'b1, 1'b0, exp_id, i[2:0], 4'h8 + i[3:0]});
      exp_e.push_back({1'b1, 4'b0010, exp_id + 3'd1});
      msg_req = 1'b1;
      wait_frame(20);
      take_frame(gf, ef, c);
      checks++;
      if (gf !== ef) begin
        errors++;
        $display("FAIL wrap_frame%0d: got %h required %h", i, gf, ef);
      end
      wait_phy(20);
      repeat (3) cyc();
      pulse_rx(exp_id);
      wait_evt(10);
      take_evt(ge, ee, c);
      checks++;
      if (ge !== ee) begin
        errors++;
        $display("FAIL wrap_done%0d: got %h required %h", i, ge, ee);
      end
      msg_req = 1'b0;
      exp_id  = exp_id + 3'd1;
      cyc();
    end
    checks++;
    if (msg_id !== 3'd0) begin
      errors++;
      $display("FAIL wrap_final_id: got %0d required 0", msg_id);
    end
  endtask

  initial begin
    test_reset();
    test_single_msg();
    test_retry_timeout();
    test_priority();
    test_nonmatch();
    test_rst_mid();
    test_hrst_abort();
    test_back_to_back_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_pd_tx_sched.md
# usb_pd_tx_sched

Transmit scheduler in front of the USB-PD PHY writer. It arbitrates between three requesters: Hard Reset, GoodCRC reply, and protocol-layer message. It sequences the PHY writer's start/busy handshake and owns the 3-bit MessageID counter. For protocol messages it waits for the partner's GoodCRC within tCRCReceive and retries on timeout.

## Interface
- system_khz, 200000, clock frequency in kHz
- CRC_TIMEOUT_US, 1000, GoodCRC wait window in µs; ticks = system_khz*CRC_TIMEOUT_US/1000
- RETRY_MAX, 2, retransmissions after the first attempt (nRetryCount)

Ports (clock and reset first):
- clock  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- hrst_req  in  1  level; request a Hard Reset
- hrst_done  out  1  1-cycle pulse; Hard Reset fully sent
- gcrc_req  in  1  level; request a GoodCRC reply
- gcrc_id  in  3  MessageID to echo; sampled at acceptance
- gcrc_ack  out  1  1-cycle pulse; GoodCRC fully sent
- msg_req  in  1  level; request a message; hold it and all msg_* stable until msg_done or msg_fail
- msg_num  in  3  data object count, 0..7
- msg_type  in  4  message type
- msg_word0..msg_word6  in  32 each  data objects
- msg_done  out  1  1-cycle pulse; matching GoodCRC received
- msg_fail  out  1  1-cycle pulse; retries exhausted, or aborted by Hard Reset
- rx_gcrc_valid  in  1  1-cycle pulse from the receiver; GoodCRC received
- rx_gcrc_id  in  3  MessageID of the received GoodCRC
- msg_id  out  3  current MessageID counter
- phy_start  out  1  1-cycle start pulse to the PHY writer
- phy_busy  in  1  PHY writer busy
- phy_hrst  out  1  1 = Hard Reset ordered set, 0 = SOP
- phy_id, phy_num, phy_type  out  3/3/4  header fields
- phy_word0..phy_word6  out  32 each  msg_word0..6 passed through combinationally

## Operation
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, WAIT_GCRC, REPORT.
- IDLE arbitration, fixed priority: hrst_req > gcrc_req > msg_req. The winner's class is latched as kind.
  - Hard Reset: phy_hrst=1.
  - GoodCRC: phy_type=4'h1, phy_num=0, phy_id=gcrc_id.
  - Message: phy_type=msg_type, phy_num=msg_num, phy_id=msg_id.
  - After latching, go to LAUNCH.
- LAUNCH: phy_start=1 for one cycle, then WAIT_BUSY.
- WAIT_BUSY: wait for phy_busy=1, then WAIT_DONE.
- WAIT_DONE: wait for phy_busy=0.
  - Hard Reset: pulse hrst_done and clear msg_id to 0.
  - GoodCRC: pulse gcrc_ack.
  - Message: clear the timer and go to WAIT_GCRC.
- WAIT_GCRC: timer increments each cycle.
  - rx_gcrc_valid with rx_gcrc_id==msg_id: pulse msg_done, msg_id increments mod 8 (7→0), go to REPORT.
  - Non-matching id: ignored; timer continues.
  - Timer reaches ticks-1 with retry_cnt<RETRY_MAX: retry_cnt++, go to LAUNCH. The retry keeps the same msg_id.
  - Timer reaches ticks-1 with retries exhausted: pulse msg_fail, go to REPORT.
  - hrst_req high: pulse msg_fail, go to IDLE. Hard Reset wins on the next arbitration.
- REPORT: one cycle, clears retry_cnt, returns to IDLE. This guarantees the requester sees its pulse before the next acceptance.
- Simultaneous match and timeout in the same cycle: the match wins (msg_done).
- rx_gcrc_valid outside WAIT_GCRC is ignored.
- hrst_req during WAIT_BUSY/WAIT_DONE: the frame in flight completes (the PHY is not abortable), then the rules above apply.
- rst mid-operation: FSM goes to IDLE, all counters clear. The PHY writer is reset separately.

## Timing
- Reset values: every output 0, msg_id=0, retry_cnt=0, timer=0.
- Request high in IDLE at cycle N: phy_start high at cycle N+1 (registered).
- phy_id/num/type/hrst are registered and stable from LAUNCH until IDLE is re-entered.
- Completion pulses (hrst_done, gcrc_ack, msg_done, msg_fail) are registered, exactly one cycle.
- GoodCRC window: exactly ticks cycles after the cycle phy_busy is first sampled low.
- Timer: 32-bit unsigned; ticks is computed at elaboration and must be ≥1.

## Configuration
- USB_PD_TX_RETRY_EN defined: retry logic as above, up to RETRY_MAX retransmissions.
- Undefined: the retry counter is not built and RETRY_MAX is ignored (treated as 0). The first timeout pulses msg_fail.

## Test plan
- msg_req, msg_num=2, msg_type=4'h2; PHY busy for 50 cycles; rx_gcrc_id=0 arrives 100 cycles later -> single phy_start; phy_id=0, phy_num=2; msg_done pulse; msg_id=1.
- msg_req, no GoodCRC, RETRY_MAX=2, USB_PD_TX_RETRY_EN set -> 3 phy_start pulses ticks apart, all with the same phy_id; then msg_fail; msg_id unchanged. Without the macro -> 1 phy_start, then msg_fail.
- hrst_req, gcrc_req (gcrc_id=5) and msg_req asserted in the same cycle -> Hard Reset sent first (phy_hrst=1), hrst_done, msg_id=0; then GoodCRC with phy_type=1, phy_id=5; then the message.
- WAIT_GCRC gets rx_gcrc_id=3 while msg_id=2 -> ignored; later timeout retries. Match and timeout in the same cycle -> msg_done.
- hrst_req raised during WAIT_GCRC -> msg_fail next cycle, then Hard Reset launched. rst asserted mid-WAIT_DONE -> all outputs 0 immediately.
- msg_id wrap: 8 successful messages -> msg_id returns to 0.
